// File: rtl/vga_pkg.sv
// Shared types, timing description, bar colour table and timing helpers
// for the VGA timing generator.
package vga_pkg;

  typedef enum logic [1:0] {
    PAT_GRID = 2'd0,
    PAT_BARS = 2'd1,
    PAT_GRAD = 2'd2,
    PAT_EXT  = 2'd3
  } pattern_e;

  typedef struct packed {
    logic [15:0] h_disp;
    logic [15:0] h_fp;
    logic [15:0] h_pulse;
    logic [15:0] h_bp;
    logic [15:0] v_disp;
    logic [15:0] v_fp;
    logic [15:0] v_pulse;
    logic [15:0] v_bp;
  } vga_timing_t;

  localparam int NUM_BARS = 8;

  // Left-to-right colour bars; the last entry also covers any remainder pixels.
  localparam logic [23:0] BAR_COLOURS [NUM_BARS] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  function automatic int h_total(input vga_timing_t t);
    return int'(t.h_disp) + int'(t.h_fp) + int'(t.h_pulse) + int'(t.h_bp);
  endfunction

  function automatic int v_total(input vga_timing_t t);
    return int'(t.v_disp) + int'(t.v_fp) + int'(t.v_pulse) + int'(t.v_bp);
  endfunction

  function automatic bit timing_legal(input vga_timing_t t);
    return (t.h_disp >= 16'd8) &&
           (t.h_fp != 16'd0) && (t.h_pulse != 16'd0) && (t.h_bp != 16'd0) &&
           (t.v_disp != 16'd0) &&
           (t.v_fp != 16'd0) && (t.v_pulse != 16'd0) && (t.v_bp != 16'd0);
  endfunction

endpackage

// File: rtl/video_if.sv
// Video output bundle: sync/blank/colour towards the display, plus the
// pixel request/response pair towards an upstream framebuffer reader.
interface video_if #(
  parameter int XW = 10,
  parameter int YW = 9
);

  logic          hs;
  logic          vs;
  logic          blank;
  logic [23:0]   rgb;
  logic          sof;
  logic          pix_req;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic [23:0]   pix_rgb;

  modport master (
    output hs, vs, blank, rgb, sof,
    output pix_req, pix_x, pix_y,
    input  pix_rgb
  );

  modport slave (
    input  hs, vs, blank, rgb, sof,
    input  pix_req, pix_x, pix_y,
    output pix_rgb
  );

endinterface

// File: rtl/vga_pattern_gen.sv
// Output-stage colour generator: maps the stage-1 pixel position and the
// frame's latched pattern to a registered RGB value, black outside the active area.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int XW        = 10,
  parameter int YW        = 9,
  parameter int HDISP     = 800,
  parameter int GRID_LOG2 = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [XW-1:0] x_i,
  input  logic [YW-1:0] y_i,
  input  pattern_e      mode_i,
  input  logic          active_i,
  input  logic [23:0]   pix_rgb_i,
  output logic [23:0]   rgb_o
);

  localparam int BAR_W = HDISP / NUM_BARS;
  localparam logic [XW-1:0] X_MASK = XW'((1 << GRID_LOG2) - 1);
  localparam logic [YW-1:0] Y_MASK = YW'((1 << GRID_LOG2) - 1);

  logic [23:0] rgb_d;
  logic [23:0] rgb_q;
  logic [23:0] pattern_rgb;
  logic [2:0]  bar_idx;
  logic [7:0]  grad;
  int          bar_div;

  always_comb begin
    pattern_rgb = 24'h000000;
    bar_div     = int'(x_i) / BAR_W;
    bar_idx     = (bar_div > NUM_BARS - 1) ? 3'd7 : 3'(bar_div);
    grad        = 8'(x_i);
    case (mode_i)
      PAT_GRID: pattern_rgb = (((x_i & X_MASK) == '0) || ((y_i & Y_MASK) == '0))
                              ? 24'hFFFFFF : 24'h000000;
      PAT_BARS: pattern_rgb = BAR_COLOURS[bar_idx];
      PAT_GRAD: pattern_rgb = {grad, grad, grad};
      default:  pattern_rgb = pix_rgb_i;
    endcase
    rgb_d = active_i ? pattern_rgb : 24'h000000;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rgb_q <= 24'h000000;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign rgb_o = rgb_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Programmable VGA timing generator: counters (stage 0), pixel request (stage 1),
// and aligned sync/blank/colour/sof outputs (stage 2).
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int HDISP     = 800,
  parameter int HFP       = 40,
  parameter int HPULSE    = 48,
  parameter int HBP       = 40,
  parameter int VDISP     = 480,
  parameter int VFP       = 13,
  parameter int VPULSE    = 3,
  parameter int VBP       = 29,
  parameter bit HS_POL    = 1'b1,
  parameter bit VS_POL    = 1'b1,
  parameter int GRID_LOG2 = 4
) (
  input  logic       pixel_clk,
  input  logic       pixel_rst_n,
  input  logic [1:0] mode,
  video_if.master    vid
);

  localparam vga_timing_t TIM = '{
    h_disp: 16'(HDISP), h_fp: 16'(HFP), h_pulse: 16'(HPULSE), h_bp: 16'(HBP),
    v_disp: 16'(VDISP), v_fp: 16'(VFP), v_pulse: 16'(VPULSE), v_bp: 16'(VBP)
  };
  localparam int H_TOTAL  = h_total(TIM);
  localparam int V_TOTAL  = v_total(TIM);
  localparam int HW       = $clog2(H_TOTAL) + 1;
  localparam int VW       = $clog2(V_TOTAL) + 1;
  localparam int XW       = $clog2(HDISP);
  localparam int YW       = $clog2(VDISP);
  localparam int HS_START = HDISP + HFP;
  localparam int HS_END   = HS_START + HPULSE - 1;
  localparam int VS_START = VDISP + VFP;
  localparam int VS_END   = VS_START + VPULSE - 1;

  if (!timing_legal(TIM)) begin : g_illegal_timing
    $error("vga_timing_gen: porch/pulse widths must be non-zero and HDISP >= 8");
  end

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  pattern_e      mode_q, mode_d;
  logic          frame_start;
  logic          active0;
  logic          hs0;
  logic          vs0;

  always_comb begin
    h_cnt_d = h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == HW'(H_TOTAL - 1)) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == VW'(V_TOTAL - 1)) ? '0 : v_cnt_q + VW'(1);
    end
  end

  // The pattern for a whole frame is decided by the mode seen at pixel (0,0).
  assign frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);
  assign mode_d      = frame_start ? pattern_e'(mode) : mode_q;
  assign active0     = (h_cnt_q < HW'(HDISP)) && (v_cnt_q < VW'(VDISP));
  assign hs0 = ((h_cnt_q >= HW'(HS_START)) && (h_cnt_q <= HW'(HS_END))) ? HS_POL : ~HS_POL;
  assign vs0 = ((v_cnt_q >= VW'(VS_START)) && (v_cnt_q <= VW'(VS_END))) ? VS_POL : ~VS_POL;

  always_ff @(posedge pixel_clk) begin
    if (!pixel_rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      mode_q  <= PAT_GRID;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      mode_q  <= mode_d;
    end
  end

  logic          pix_req_q, pix_req_d;
  logic [XW-1:0] pix_x_q, pix_x_d;
  logic [YW-1:0] pix_y_q, pix_y_d;
  logic          s1_active_q;
  logic          s1_hs_q;
  logic          s1_vs_q;
  logic          s1_sof_q;
  pattern_e      s1_mode_q;
  logic [XW-1:0] s1_x_q;
  logic [YW-1:0] s1_y_q;

  // Request coordinates are held between requests so the reader sees stable addresses.
  always_comb begin
    pix_req_d = active0 && (mode_d == PAT_EXT);
    pix_x_d   = pix_x_q;
    pix_y_d   = pix_y_q;
    if (pix_req_d) begin
      pix_x_d = XW'(h_cnt_q);
      pix_y_d = YW'(v_cnt_q);
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (!pixel_rst_n) begin
      pix_req_q   <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      s1_active_q <= 1'b0;
      s1_hs_q     <= ~HS_POL;
      s1_vs_q     <= ~VS_POL;
      s1_sof_q    <= 1'b0;
      s1_mode_q   <= PAT_GRID;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
    end else begin
      pix_req_q   <= pix_req_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      s1_active_q <= active0;
      s1_hs_q     <= hs0;
      s1_vs_q     <= vs0;
      s1_sof_q    <= frame_start;
      s1_mode_q   <= mode_d;
      s1_x_q      <= XW'(h_cnt_q);
      s1_y_q      <= YW'(v_cnt_q);
    end
  end

  logic        hs_q;
  logic        vs_q;
  logic        blank_q;
  logic        sof_q;
  logic [23:0] rgb_w;

  always_ff @(posedge pixel_clk) begin
    if (!pixel_rst_n) begin
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      blank_q <= 1'b1;
      sof_q   <= 1'b0;
    end else begin
      hs_q    <= s1_hs_q;
      vs_q    <= s1_vs_q;
      blank_q <= ~s1_active_q;
      sof_q   <= s1_sof_q;
    end
  end

  vga_pattern_gen #(
    .XW        (XW),
    .YW        (YW),
    .HDISP     (HDISP),
    .GRID_LOG2 (GRID_LOG2)
  ) u_pattern (
    .clk_i     (pixel_clk),
    .rst_ni    (pixel_rst_n),
    .x_i       (s1_x_q),
    .y_i       (s1_y_q),
    .mode_i    (s1_mode_q),
    .active_i  (s1_active_q),
    .pix_rgb_i (vid.pix_rgb),
    .rgb_o     (rgb_w)
  );

  assign vid.hs      = hs_q;
  assign vid.vs      = vs_q;
  assign vid.blank   = blank_q;
  assign vid.sof     = sof_q;
  assign vid.rgb     = rgb_w;
  assign vid.pix_req = pix_req_q;
  assign vid.pix_x   = pix_x_q;
  assign vid.pix_y   = pix_y_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a tiny 14x8 raster; a reference model pushes
// expected stage-1/stage-2 values into a scoreboard that is drained as outputs appear.
module tb_vga_timing_gen;

  localparam int XW = 3;
  localparam int YW = 2;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic [1:0] mode = 2'd0;

  video_if #(.XW(XW), .YW(YW)) vid ();

  vga_timing_gen #(
    .HDISP(8), .HFP(2), .HPULSE(3), .HBP(1),
    .VDISP(4), .VFP(1), .VPULSE(2), .VBP(1),
    .HS_POL(1'b0), .VS_POL(1'b1), .GRID_LOG2(2)
  ) dut (
    .pixel_clk   (clk),
    .pixel_rst_n (rstN),
    .mode        (mode),
    .vid         (vid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          req;
    logic [XW-1:0] px;
    logic [YW-1:0] py;
    logic          hs;
    logic          vs;
    logic          blank;
    logic          sof;
    logic [23:0]   rgb;
  } expect_t;

  expect_t     scoreQ[$];
  int          sofSteps[$];
  int          errors = 0;
  int          checks = 0;
  int          stepCount = 0;
  int          reqCount = 0;
  int          mh = 0;
  int          mv = 0;
  logic [1:0]  modeLatched = 2'd0;
  logic [XW-1:0] lastPx = '0;
  logic [YW-1:0] lastPy = '0;
  logic [23:0] barTable [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s step=%0d observed=%0h expected=%0h", tag, stepCount, obs, exp);
    end
  endtask

  task automatic checkStage1(input expect_t e);
    checkOutput("pix_req", 32'(vid.pix_req), 32'(e.req));
    checkOutput("pix_x", 32'(vid.pix_x), 32'(e.px));
    checkOutput("pix_y", 32'(vid.pix_y), 32'(e.py));
  endtask

  task automatic checkStage2(input expect_t e);
    checkOutput("hs", 32'(vid.hs), 32'(e.hs));
    checkOutput("vs", 32'(vid.vs), 32'(e.vs));
    checkOutput("blank", 32'(vid.blank), 32'(e.blank));
    checkOutput("sof", 32'(vid.sof), 32'(e.sof));
    checkOutput("rgb", 32'(vid.rgb), 32'(e.rgb));
  endtask

  // Framebuffer reader model: answers a request in time for the next edge.
  task automatic respond();
    if (vid.pix_req === 1'b1) begin
      reqCount++;
      vid.pix_rgb = {8'(vid.pix_y), 8'(vid.pix_x), 8'h5A};
    end else begin
      vid.pix_rgb = 24'($urandom);
    end
    if (vid.sof === 1'b1) sofSteps.push_back(stepCount);
  endtask

  task automatic applyStimulus();
    expect_t    e;
    logic [1:0] m;
    logic       act;
    m = (mh == 0 && mv == 0) ? mode : modeLatched;
    modeLatched = m;
    act = (mh < 8) && (mv < 4);
    e.req = act && (m == 2'd3);
    if (e.req) begin
      lastPx = 3'(mh);
      lastPy = 2'(mv);
    end
    e.px = lastPx;
    e.py = lastPy;
    e.hs = (mh >= 10 && mh <= 12) ? 1'b0 : 1'b1;
    e.vs = (mv >= 5 && mv <= 6) ? 1'b1 : 1'b0;
    e.blank = !act;
    e.sof = (mh == 0 && mv == 0);
    e.rgb = 24'h000000;
    if (act) begin
      case (m)
        2'd0: e.rgb = ((mh % 4 == 0) || (mv % 4 == 0)) ? 24'hFFFFFF : 24'h000000;
        2'd1: e.rgb = barTable[mh];
        2'd2: e.rgb = {3{8'(mh)}};
        default: e.rgb = {8'(mv), 8'(mh), 8'h5A};
      endcase
    end
    scoreQ.push_back(e);
    @(posedge clk);
    #1;
    stepCount++;
    mh++;
    if (mh == 14) begin
      mh = 0;
      mv = (mv == 7) ? 0 : mv + 1;
    end
    checkStage1(scoreQ[$]);
    if (scoreQ.size() >= 2) begin
      e = scoreQ.pop_front();
      checkStage2(e);
    end
    respond();
  endtask

  task automatic applyReset();
    expect_t e;
    rstN = 1'b0;
    scoreQ.delete();
    mh = 0;
    mv = 0;
    modeLatched = 2'd0;
    lastPx = '0;
    lastPy = '0;
    e.req = 1'b0;
    e.px = '0;
    e.py = '0;
    e.hs = 1'b1;
    e.vs = 1'b0;
    e.blank = 1'b1;
    e.sof = 1'b0;
    e.rgb = 24'h000000;
    scoreQ.push_back(e);
    @(posedge clk);
    #1;
    checkStage1(e);
    checkStage2(e);
    respond();
  endtask

  task automatic releaseReset();
    rstN = 1'b1;
    stepCount = 0;
    sofSteps.delete();
  endtask

  task automatic checkSofTiming(input string tag);
    checkOutput({tag, "_sof_count_ge2"}, 32'(sofSteps.size() >= 2), 32'd1);
    if (sofSteps.size() >= 2) begin
      checkOutput({tag, "_first_sof_step"}, 32'(sofSteps[0]), 32'd2);
      checkOutput({tag, "_frame_period"}, 32'(sofSteps[1] - sofSteps[0]), 32'd112);
    end
  endtask

  initial begin
    $display("[TB] vga_timing_gen bench start");
    vid.pix_rgb = 24'h000000;

    repeat (3) applyReset();
    releaseReset();

    // Grid frames, sync polarity and frame period.
    repeat (224) applyStimulus();
    checkSofTiming("grid");

    // Colour bars for a full frame.
    mode = 2'd1;
    repeat (112) applyStimulus();

    // External pixel source: exactly one request per active pixel.
    mode = 2'd3;
    reqCount = 0;
    repeat (112) applyStimulus();
    checkOutput("pix_req_per_frame", 32'(reqCount), 32'd32);

    // Mid-frame switch to gradient only takes effect at the next frame.
    mode = 2'd0;
    repeat (28) applyStimulus();
    mode = 2'd2;
    repeat (84) applyStimulus();
    reqCount = 0;
    repeat (112) applyStimulus();
    checkOutput("pix_req_outside_ext", 32'(reqCount), 32'd0);

    // Reset in the middle of line 2, pixel 3, then a clean restart.
    repeat (31) applyStimulus();
    applyReset();
    mode = 2'd0;
    releaseReset();
    repeat (114) applyStimulus();
    checkSofTiming("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
